// File: rtl/fadd_pipe.sv
// Pipelined binary32 adder: align -> add -> normalize/round, NSTAGE (1..3) register stages.
// Denormals are flushed to zero; overflow saturates to signed infinity with ovf set.
module fadd_pipe #(
  parameter int unsigned NSTAGE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        valid_out,
  output logic [31:0] y,
  output logic        ovf
);

  typedef struct packed {
    logic        v;
    logic        sign;
    logic        zsign;
    logic        fin;
    logic        sub;
    logic [7:0]  exp;
    logic [23:0] sig_a;
    logic [26:0] sig_b;  // {significand, guard, round, sticky}
  } align_t;

  typedef struct packed {
    logic        v;
    logic        sign;
    logic        zsign;
    logic        fin;
    logic [7:0]  exp;
    logic [27:0] sum;
  } add_t;

  typedef struct packed {
    logic        v;
    logic [31:0] y;
    logic        ovf;
  } res_t;

  align_t align_d, align_q;
  add_t   add_d, add_p;
  res_t   res_d, res_p;

  logic [30:0] mag1, mag2, mag_a, mag_b;
  logic        swap, sgn_a, sgn_b;
  logic [23:0] sig_bn;
  logic [7:0]  dexp;
  logic [49:0] sh;

  always_comb begin
    mag1   = (x1[30:23] == 8'd0) ? 31'd0 : x1[30:0];
    mag2   = (x2[30:23] == 8'd0) ? 31'd0 : x2[30:0];
    swap   = mag2 > mag1;
    mag_a  = swap ? mag2 : mag1;
    mag_b  = swap ? mag1 : mag2;
    sgn_a  = swap ? x2[31] : x1[31];
    sgn_b  = swap ? x1[31] : x2[31];
    sig_bn = (mag_b[30:23] == 8'd0) ? 24'd0 : {1'b1, mag_b[22:0]};
    dexp   = mag_a[30:23] - mag_b[30:23];
    sh     = {sig_bn, 26'd0} >> dexp;

    align_d       = '0;
    align_d.v     = valid_in;
    align_d.sign  = sgn_a;
    align_d.sub   = sgn_a ^ sgn_b;
    // Only two negative zeros can produce -0; cancellation always gives +0.
    align_d.zsign = sgn_a & sgn_b;
    align_d.fin   = (x1[30:23] != 8'hFF) && (x2[30:23] != 8'hFF);
    align_d.exp   = mag_a[30:23];
    align_d.sig_a = (mag_a[30:23] == 8'd0) ? 24'd0 : {1'b1, mag_a[22:0]};
    align_d.sig_b = (dexp >= 8'd26) ? {26'd0, |sig_bn} : {sh[49:24], |sh[23:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) align_q <= '0;
    else     align_q <= align_d;
  end

  always_comb begin
    add_d       = '0;
    add_d.v     = align_q.v;
    add_d.sign  = align_q.sign;
    add_d.zsign = align_q.zsign;
    add_d.fin   = align_q.fin;
    add_d.exp   = align_q.exp;
    add_d.sum   = align_q.sub ? ({1'b0, align_q.sig_a, 3'b000} - {1'b0, align_q.sig_b})
                              : ({1'b0, align_q.sig_a, 3'b000} + {1'b0, align_q.sig_b});
  end

  generate
    if (NSTAGE >= 2) begin : g_add_reg
      add_t add_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) add_q <= '0;
        else     add_q <= add_d;
      end
      assign add_p = add_q;
    end else begin : g_add_comb
      assign add_p = add_d;
    end
  endgenerate

  logic [4:0]        lzc;
  logic [26:0]       norm;
  logic [23:0]       sig;
  logic              grd, stk;
  logic [24:0]       rnd;
  logic signed [9:0] exp_n, exp_r;
  logic [22:0]       mant;

  always_comb begin
    lzc = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (add_p.sum[i]) lzc = 5'(26 - i);
    end
    norm = add_p.sum[26:0] << lzc;
    if (add_p.sum[27]) begin
      sig   = add_p.sum[27:4];
      grd   = add_p.sum[3];
      stk   = |add_p.sum[2:0];
      exp_n = $signed({2'b00, add_p.exp}) + 10'sd1;
    end else begin
      sig   = norm[26:3];
      grd   = norm[2];
      stk   = |norm[1:0];
      exp_n = $signed({2'b00, add_p.exp}) - $signed({5'd0, lzc});
    end
    rnd = {1'b0, sig} + {24'd0, grd & (stk | sig[0])};
    if (rnd[24]) begin
      exp_r = exp_n + 10'sd1;
      mant  = rnd[23:1];
    end else begin
      exp_r = exp_n;
      mant  = rnd[22:0];
    end

    res_d   = '0;
    res_d.v = add_p.v;
    if (add_p.sum == 28'd0) begin
      res_d.y = {add_p.zsign, 31'd0};
    end else if (exp_r <= 10'sd0) begin
      res_d.y = {add_p.sign, 31'd0};
    end else if (exp_r >= 10'sd255) begin
      res_d.y   = {add_p.sign, 8'hFF, 23'd0};
      res_d.ovf = add_p.fin;
    end else begin
      res_d.y = {add_p.sign, exp_r[7:0], mant};
    end
  end

  generate
    if (NSTAGE >= 3) begin : g_res_reg
      res_t res_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) res_q <= '0;
        else     res_q <= res_d;
      end
      assign res_p = res_q;
    end else begin : g_res_comb
      assign res_p = res_d;
    end
  endgenerate

  assign valid_out = res_p.v;
  assign y         = res_p.y;
  assign ovf       = res_p.ovf;

endmodule

// File: tb/tb_fadd_pipe.sv
// Scoreboard bench for fadd_pipe: directed spec vectors plus random ops checked against a
// real-arithmetic model rounded to binary32 with flush-to-zero and overflow saturation.
module tb_fadd_pipe;
  localparam int unsigned NSTAGE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] x1 = 32'd0;
  logic [31:0] x2 = 32'd0;
  logic        valid_out;
  logic [31:0] y;
  logic        ovf;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] sb_y[$];
  logic        sb_o[$];
  logic        vhist[$];

  fadd_pipe #(.NSTAGE(NSTAGE)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .x1        (x1),
    .x2        (x2),
    .valid_out (valid_out),
    .y         (y),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic real to_real(input logic [31:0] a);
    logic [63:0] b;
    if (a[30:23] == 8'd0) b = {a[31], 63'd0};
    else b = {a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  // Exact-enough real sum (double), then round-to-nearest-even into binary32.
  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ry, output logic ro);
    real         r;
    logic [63:0] bits;
    int          e;
    logic [24:0] m;
    r  = to_real(a) + to_real(b);
    ro = 1'b0;
    if (r == 0.0) begin
      ry = {a[31] & b[31], 31'd0};
    end else begin
      bits = $realtobits(r);
      e    = int'(bits[62:52]) - 1023 + 127;
      m    = {2'b01, bits[51:29]};
      if (bits[28] && ((|bits[27:0]) || bits[29])) m = m + 25'd1;
      if (m[24]) begin
        e++;
        m = m >> 1;
      end
      if (e <= 0) ry = {bits[63], 31'd0};
      else if (e >= 255) begin
        ry = {bits[63], 8'hFF, 23'd0};
        ro = 1'b1;
      end else ry = {bits[63], 8'(e), m[22:0]};
    end
  endfunction

  function automatic logic [31:0] rand_fp(input int center);
    logic [31:0] r;
    int          e;
    r = $urandom;
    if ($urandom_range(0, 9) == 0) e = 0;
    else begin
      e = center + int'($urandom_range(0, 60)) - 30;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
    end
    r[30:23] = 8'(e);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ey, input logic eo);
    @(posedge clk);
    #1;
    valid_in = v;
    x1       = a;
    x2       = b;
    if (v) begin
      sb_y.push_back(ey);
      sb_o.push_back(eo);
    end
  endtask

  task automatic drive_rand(input logic v);
    logic [31:0] a, b, ey;
    logic        eo;
    int          c;
    c = ($urandom_range(0, 7) == 0) ? 252 : int'($urandom_range(1, 254));
    a = rand_fp(c);
    if ($urandom_range(0, 7) == 0) b = {~a[31], a[30:8], 8'($urandom)};
    else b = rand_fp(c);
    ref_add(a, b, ey, eo);
    drive(v, a, b, ey, eo);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_out"}, {31'd0, valid_out}, 32'd0);
    check({tag, "_y"}, y, 32'd0);
    check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  always @(posedge clk) begin
    if (!rst) vhist.push_back(valid_in);
  end

  always @(negedge clk) begin : p_mon
    logic        ev;
    logic [31:0] ey;
    logic        eo;
    if (!rst) begin
      ev = (vhist.size() >= NSTAGE) ? vhist.pop_front() : 1'b0;
      check("valid_out", {31'd0, valid_out}, {31'd0, ev});
      if (valid_out) begin
        if (sb_y.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got y=%h with no op outstanding", y);
        end else begin
          ey = sb_y.pop_front();
          eo = sb_o.pop_front();
          check("y", y, ey);
          check("ovf", {31'd0, ovf}, {31'd0, eo});
        end
      end
    end
  end

  initial begin
    logic bubbles[5];
    bubbles = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    drive(1'b1, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0);
    drive(1'b1, 32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0);
    drive(1'b1, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0);
    drive(1'b1, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
    drive(1'b1, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0);
    drive(1'b1, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0);
    drive(1'b1, 32'h3F800000, 32'h33C00000, 32'h3F800001, 1'b0);
    drive(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1);
    drive(1'b1, 32'hFF7FFFFF, 32'hFF000000, 32'hFF800000, 1'b1);
    drive(1'b1, 32'h00400000, 32'h00000000, 32'h00000000, 1'b0);
    drive(1'b1, 32'h4B000001, 32'hCB000000, 32'h3F800000, 1'b0);
    drive(1'b1, 32'h00800000, 32'h80800001, 32'h80000000, 1'b0);
    drive(1'b1, 32'h3F800000, 32'h00000000, 32'h3F800000, 1'b0);

    for (int i = 0; i < 20; i++) drive_rand(1'b1);
    for (int i = 0; i < 5; i++) drive_rand(bubbles[i]);
    for (int i = 0; i < 6; i++) drive_rand(1'b1);

    @(posedge clk);
    #1;
    rst      = 1'b1;
    valid_in = 1'b0;
    sb_y.delete();
    sb_o.delete();
    vhist.delete();
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) drive(1'b0, 32'h3F800000, 32'h3F800000, 32'd0, 1'b0);

    for (int i = 0; i < 400; i++) drive_rand(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    repeat (NSTAGE + 4) drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    check("drain_outstanding", 32'(sb_y.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
